// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits, zero-latency reads
// and same-cycle writeback bypass. Register 0 is hardwired to zero.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_ready,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic [AW:0]         pending_cnt
);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;
    logic [AW:0]      cnt_next;
    logic             iss_hit;
    logic             wb_hit;
    logic             cnt_inc;
    logic             cnt_dec;

    assign iss_hit = iss_valid && (iss_addr != '0);
    assign wb_hit  = wb_valid && (wb_addr != '0);

    // A writeback only retires the pending bit if no new producer claims the same register.
    assign cnt_inc = iss_hit && !pending[iss_addr];
    assign cnt_dec = wb_hit && pending[wb_addr] && !(iss_hit && (iss_addr == wb_addr));

    always_comb begin
        pending_next = pending;
        if (wb_hit) begin
            pending_next[wb_addr] = 1'b0;
        end
        if (iss_hit) begin
            pending_next[iss_addr] = 1'b1;
        end
        cnt_next = pending_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            if (wb_hit) begin
                regs[wb_addr] <= wb_data;
            end
            pending     <= pending_next;
            pending_cnt <= cnt_next;
        end
    end

    genvar k;
    for (k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            bypass;
        logic [XLEN-1:0] data;
        logic            ready;

        assign addr   = rd_addr[k*AW +: AW];
        assign bypass = wb_hit && (addr == wb_addr);

        // While reset is held the array may still hold stale values, so mask them.
        always_comb begin
            data  = regs[addr];
            ready = !pending[addr];
            if (addr == '0) begin
                data  = '0;
                ready = 1'b1;
            end else if (bypass) begin
                data  = wb_data;
                ready = 1'b1;
            end else if (rst) begin
                data  = '0;
                ready = 1'b1;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data;
        assign rd_ready[k]             = ready;
    end

endmodule
